// File: rtl/led_fader_pkg.sv
// led_fader_pkg: shared types and defaults for the LED fader.
//   ch_state_e   - per-channel fade state (OFF=0, RISE=1, ON=2, FALL=3)
//   PWM_BITS_DEF - default PWM / brightness width
//   RAMP_DIV_DEF - default ramp prescaler terminal count (~1 s full ramp at 6 MHz)
package led_fader_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } ch_state_e;

  localparam int unsigned PWM_BITS_DEF = 8;
  localparam int unsigned RAMP_DIV_DEF = 23436;

  // Channel state from where the level sits relative to its target.
  function automatic ch_state_e derive_state(input logic at_zero,
                                             input logic at_max,
                                             input logic tgt_on);
    if (tgt_on) begin
      return at_max ? ST_ON : ST_RISE;
    end
    return at_zero ? ST_OFF : ST_FALL;
  endfunction

endpackage

// File: rtl/led_fader_if.sv
// led_fader_if: pattern-in / LED-out bundle between sequencer and fader.
//   seq  - target pattern, bit i = 1 requests LED i on
//   led  - PWM drive per LED, 1 = lit
//   busy - any channel still ramping
// master: sequencer / board side; slave: the fader.
interface led_fader_if #(
  parameter int unsigned WORD_SIZE = 2
);
  logic [WORD_SIZE-1:0] seq;
  logic [WORD_SIZE-1:0] led;
  logic                 busy;

  modport master (output seq, input led, input busy);
  modport slave  (input seq, output led, output busy);
endinterface

// File: rtl/led_fader_fade_channel.sv
// fade_channel: one LED channel - brightness level, fade state and PWM compare.
//   clock, reset - system clock, async active-high reset
//   tick         - shared ramp step strobe
//   tgt_on       - current registered target (1 = full, 0 = off)
//   tgt_on_next  - target being loaded this edge, so state lines up with it
//   pwm_cnt      - shared free-running PWM counter
//   led          - registered PWM output
//   state        - registered fade state
// Build option: LED_FADER_GAMMA_EN selects a quadratic brightness curve.
module fade_channel
  import led_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic                tgt_on,
  input  logic                tgt_on_next,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output ch_state_e           state
);

  localparam logic [PWM_BITS-1:0] MAX    = '1;
  localparam int unsigned         PROD_W = 2 * PWM_BITS;

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] level_d;
  logic [PWM_BITS-1:0] eff;

  // One saturating step toward the target per tick.
  always_comb begin
    level_d = level;
    if (tick) begin
      if (tgt_on && (level != MAX)) begin
        level_d = level + PWM_BITS'(1);
      end else if (!tgt_on && (level != '0)) begin
        level_d = level - PWM_BITS'(1);
      end
    end
  end

`ifdef LED_FADER_GAMMA_EN
  // Perceptual curve: upper half of level squared.
  logic [PROD_W-1:0] level_sq;
  always_comb begin
    level_sq = PROD_W'(level) * PROD_W'(level);
    eff      = level_sq[PROD_W-1:PWM_BITS];
  end
`else
  always_comb begin
    eff = level;
  end
`endif

  // State follows the post-edge level and target; full level forces solid on.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level <= '0;
      state <= ST_OFF;
      led   <= 1'b0;
    end else begin
      level <= level_d;
      state <= derive_state(level_d == '0, level_d == MAX, tgt_on_next);
      led   <= (eff > pwm_cnt) | (level == MAX);
    end
  end

endmodule

// File: rtl/led_fader.sv
// led_fader: per-bit LED brightness fader between sequencer and LED pins.
//   clock - system clock
//   reset - async active-high reset
//   bus   - led_fader_if slave: seq in, led / busy out
// Parameters: WORD_SIZE channels, PWM_BITS level width, RAMP_DIV prescaler
// terminal count (one level step every RAMP_DIV+1 clocks).
// Build option: LED_FADER_GAMMA_EN enables the quadratic curve in each channel.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 2,
  parameter int unsigned PWM_BITS  = PWM_BITS_DEF,
  parameter int unsigned RAMP_DIV  = RAMP_DIV_DEF
) (
  input logic        clock,
  input logic        reset,
  led_fader_if.slave bus
);

  localparam int unsigned RAMP_W = (RAMP_DIV > 0) ? $clog2(RAMP_DIV + 1) : 1;

  logic [WORD_SIZE-1:0] seq_q;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [RAMP_W-1:0]    ramp_cnt;
  logic                 tick;
  logic [WORD_SIZE-1:0] led_bits;
  ch_state_e            ch_state [WORD_SIZE];
  logic                 busy_c;

  assign tick = (ramp_cnt == RAMP_W'(RAMP_DIV));

  // Input sampling, free-running PWM counter, ramp prescaler.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seq_q    <= '0;
      pwm_cnt  <= '0;
      ramp_cnt <= '0;
    end else begin
      seq_q    <= bus.seq;
      pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
      ramp_cnt <= tick ? '0 : ramp_cnt + RAMP_W'(1);
    end
  end

  for (genvar g = 0; g < WORD_SIZE; g++) begin : g_ch
    fade_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .tick        (tick),
      .tgt_on      (seq_q[g]),
      .tgt_on_next (bus.seq[g]),
      .pwm_cnt     (pwm_cnt),
      .led         (led_bits[g]),
      .state       (ch_state[g])
    );
  end

  // Busy while any channel is mid-ramp.
  always_comb begin
    busy_c = 1'b0;
    for (int i = 0; i < WORD_SIZE; i++) begin
      if ((ch_state[i] == ST_RISE) || (ch_state[i] == ST_FALL)) begin
        busy_c = 1'b1;
      end
    end
  end

  assign bus.led  = led_bits;
  assign bus.busy = busy_c;

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: scoreboard bench for led_fader (WORD_SIZE=2, PWM_BITS=4, RAMP_DIV=1).
module tb_led_fader;

  localparam int W    = 2;
  localparam int PB   = 4;
  localparam int RD   = 1;
  localparam int MAXL = 15;

  typedef struct packed {
    logic [1:0] led;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_fader_if #(.WORD_SIZE(W)) bus ();

  led_fader #(
    .WORD_SIZE (W),
    .PWM_BITS  (PB),
    .RAMP_DIV  (RD)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  // Reference model state (values after the most recent edge)
  logic [1:0] m_seq_q;
  int         m_pwm;
  int         m_ramp;
  int         m_lvl[2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_of(input int lvl);
`ifdef LED_FADER_GAMMA_EN
    return (lvl * lvl) >> PB;
`else
    return lvl;
`endif
  endfunction

  task automatic model_reset();
    m_seq_q  = 2'b00;
    m_pwm    = 0;
    m_ramp   = 0;
    m_lvl[0] = 0;
    m_lvl[1] = 0;
  endtask

  // Predict outputs after the next edge given input s, and queue them.
  task automatic model_edge(input logic [1:0] s);
    exp_t e;
    logic tk;
    int   tgt;
    tk = (m_ramp == RD);
    for (int i = 0; i < 2; i++) begin
      e.led[i] = (eff_of(m_lvl[i]) > m_pwm) || (m_lvl[i] == MAXL);
    end
    if (tk) begin
      for (int i = 0; i < 2; i++) begin
        tgt = m_seq_q[i] ? MAXL : 0;
        if (m_lvl[i] < tgt) m_lvl[i]++;
        else if (m_lvl[i] > tgt) m_lvl[i]--;
      end
    end
    m_seq_q = s;
    m_pwm   = (m_pwm + 1) % (1 << PB);
    m_ramp  = tk ? 0 : m_ramp + 1;
    e.busy  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (m_seq_q[i] ? (m_lvl[i] != MAXL) : (m_lvl[i] != 0)) e.busy = 1'b1;
    end
    sb_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, then compare after the edge.
  task automatic step(input logic [1:0] s);
    exp_t e;
    bus.seq = s;
    model_edge(s);
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("led", int'(bus.led), int'(e.led));
      check("busy", int'(bus.busy), int'(e.busy));
    end
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic reset_mid();
    rst = 1'b1;
    #1;
    check("rst_led", int'(bus.led), 0);
    check("rst_busy", int'(bus.busy), 0);
    #1;
    rst = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  initial begin
    int guard;
    bus.seq = 2'b00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("init_led", int'(bus.led), 0);
    check("init_busy", int'(bus.busy), 0);
    #2;
    rst = 1'b0;

    // Idle
    repeat (8) step(2'b00);

    // Rise on channel 0 to full, then hold solid
    repeat (45) step(2'b01);

    // Fall partway, then reset mid-ramp
    repeat (9) step(2'b00);
    reset_mid();

    // Reversal at level 6
    guard = 0;
    while (m_lvl[0] != 6 && guard < 100) begin
      step(2'b01);
      guard++;
    end
    check("reach_lvl6", m_lvl[0], 6);
    repeat (30) step(2'b00);

    // Independent channels: ch1 leads ch0 by 10 clocks
    repeat (10) step(2'b10);
    repeat (50) step(2'b11);
    repeat (40) step(2'b00);

    // Tick collision: change target on an edge that is also a tick
    guard = 0;
    while (m_ramp != RD && guard < 10) begin
      step(2'b00);
      guard++;
    end
    step(2'b01);
    repeat (12) step(2'b01);
    guard = 0;
    while (m_ramp != RD && guard < 10) begin
      step(2'b01);
      guard++;
    end
    step(2'b00);
    repeat (30) step(2'b00);

    // Random pattern changes
    for (int k = 0; k < 300; k++) begin
      step(2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 6)) step(m_seq_q);
    end

    // Settle and confirm idle
    repeat (40) step(2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
